// File: rtl/rd_sched_pkg.sv
// Shared types for the RdSchedule descriptor path: descriptor layout and scheduler state.
package rd_sched_pkg;

    localparam int DESC_W     = 20;
    localparam int DESC_PTR_W = 9;
    localparam int DESC_LEN_W = 11;

    typedef struct packed {
        logic [DESC_PTR_W-1:0] ptr;
        logic [DESC_LEN_W-1:0] len;
    } desc_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rd_sched_rr_arb.sv
// Queue arbiter: round robin from rr_ptr, or strict priority (queue 0 highest)
// when RD_SCHED_STRICT_PRIO_EN is defined.
module rd_sched_rr_arb
    import rd_sched_pkg::*;
#(
    parameter int NUM_Q = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NUM_Q-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [IDX_W-1:0] start;

`ifdef RD_SCHED_STRICT_PRIO_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;
    assign start = '0;
`else
    assign start = rr_ptr;
`endif

    // Strict priority is the same upward search, just always anchored at queue 0.
    always_comb begin : search
        int idx;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_Q; k++) begin
            idx = (int'(start) + k) % NUM_Q;
            if (!gnt_valid && req[idx[IDX_W-1:0]]) begin
                gnt_valid                = 1'b1;
                gnt[idx[IDX_W-1:0]]      = 1'b1;
                gnt_idx                  = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rd_sched_desc_arb.sv
// Pops descriptors from NUM_Q queue FIFOs, drops illegal lengths, and keeps exactly one
// frame read in flight. Define RD_SCHED_STRICT_PRIO_EN for strict-priority arbitration.
module rd_sched_desc_arb
    import rd_sched_pkg::*;
#(
    parameter int NUM_Q      = 4,
    parameter int PTR_W      = DESC_PTR_W,
    parameter int LEN_W      = DESC_LEN_W,
    parameter int PAGE_BYTES = 64,
    parameter int MAX_LEN    = 1518,
    parameter int CNT_W      = 16,
    localparam int QID_W     = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    localparam int PG_SHIFT  = $clog2(PAGE_BYTES),
    localparam int PAGES_W   = LEN_W + 1 - PG_SHIFT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [NUM_Q-1:0]        q_empty_i,
    input  logic [NUM_Q*DESC_W-1:0] q_data_i,
    output logic [NUM_Q-1:0]        q_pop_o,
    output logic                    desc_valid_o,
    input  logic                    desc_ready_i,
    output logic [PTR_W-1:0]        desc_ptr_o,
    output logic [LEN_W-1:0]        desc_len_o,
    output logic [PAGES_W-1:0]      desc_pages_o,
    output logic [QID_W-1:0]        desc_qid_o,
    input  logic                    rd_done_i,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W:0]   PG_ROUND  = (LEN_W+1)'(PAGE_BYTES - 1);

    state_e           state_q, state_d;
    logic [QID_W-1:0] rr_q;
    logic [NUM_Q-1:0] gnt;
    logic [QID_W-1:0] gnt_idx;
    logic             gnt_valid;
    desc_t            head;
    logic             take;
    logic             legal;
    logic [LEN_W:0]   len_round;

    rd_sched_rr_arb #(
        .NUM_Q (NUM_Q),
        .IDX_W (QID_W)
    ) u_arb (
        .req       (~q_empty_i),
        .rr_ptr    (rr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign head      = q_data_i[gnt_idx*DESC_W +: DESC_W];
    assign take      = (state_q == IDLE) && gnt_valid && !flush_i;
    assign legal     = (head.len != '0) && (head.len <= MAX_LEN_L);
    assign len_round = {1'b0, head.len} + PG_ROUND;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (gnt_valid && legal) state_d = ISSUE;
                ISSUE:     if (desc_ready_i)       state_d = WAIT_DONE;
                WAIT_DONE: if (rd_done_i)          state_d = IDLE;
                default:                           state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        q_pop_o      = take ? gnt : '0;
        desc_valid_o = (state_q == ISSUE);
        busy_o       = (state_q != IDLE);
    end

    // The popped entry is captured even when it gets dropped; only the FSM decides whether it is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            desc_ptr_o   <= '0;
            desc_len_o   <= '0;
            desc_pages_o <= '0;
            desc_qid_o   <= '0;
        end else if (flush_i) begin
            desc_ptr_o   <= '0;
            desc_len_o   <= '0;
            desc_pages_o <= '0;
            desc_qid_o   <= '0;
        end else if (take) begin
            desc_ptr_o   <= head.ptr;
            desc_len_o   <= head.len;
            desc_pages_o <= PAGES_W'(len_round >> PG_SHIFT);
            desc_qid_o   <= gnt_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (take) begin
`ifdef RD_SCHED_STRICT_PRIO_EN
            rr_q <= '0;
`else
            rr_q <= (gnt_idx == QID_W'(NUM_Q - 1)) ? '0 : gnt_idx + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_o <= '0;
        end else if (take && !legal && (drop_cnt_o != '1)) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_rd_sched_desc_arb.sv
// Directed bench for rd_sched_desc_arb with behavioural queue FIFOs feeding the arbiter.
module tb_rd_sched_desc_arb;
    import rd_sched_pkg::*;

    localparam int NUM_Q = 4;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  q_empty = 4'hF;
    logic [79:0] q_data = '0;
    logic [3:0]  q_pop;
    logic        valid;
    logic        ready = 1'b0;
    logic [8:0]  ptr;
    logic [10:0] len;
    logic [5:0]  pages;
    logic [1:0]  qid;
    logic        rd_done = 1'b0;
    logic        busy;
    logic [3:0]  drop;

    logic [19:0] fifo [NUM_Q][$];
    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int pop_base = 0;
    int e_q [5];
    int e_p [5];

    always #5 clk = ~clk;

    rd_sched_desc_arb #(
        .NUM_Q (NUM_Q),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .q_empty_i    (q_empty),
        .q_data_i     (q_data),
        .q_pop_o      (q_pop),
        .desc_valid_o (valid),
        .desc_ready_i (ready),
        .desc_ptr_o   (ptr),
        .desc_len_o   (len),
        .desc_pages_o (pages),
        .desc_qid_o   (qid),
        .rd_done_i    (rd_done),
        .busy_o       (busy),
        .drop_cnt_o   (drop)
    );

    // Queue FIFOs: pop on the clock edge, present the new head at the falling edge.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_Q; i++) begin
            if (q_pop[i]) begin
                pop_cnt++;
                if (fifo[i].size() > 0) void'(fifo[i].pop_front());
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NUM_Q; i++) begin
            q_empty[i] = (fifo[i].size() == 0);
            q_data[i*20 +: 20] = (fifo[i].size() > 0) ? fifo[i][0] : 20'h0;
        end
    end

    function automatic logic [19:0] d(input logic [8:0] p, input logic [10:0] l);
        return {p, l};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        flush   = 1'b0;
        ready   = 1'b0;
        rd_done = 1'b0;
        for (int i = 0; i < NUM_Q; i++) fifo[i].delete();
        cyc();
        cyc();
        check({tag, "_rst_pop"}, q_pop, 0);
        check({tag, "_rst_valid"}, valid, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_drop"}, drop, 0);
        check({tag, "_rst_desc"}, {ptr, len, pages, qid}, 0);
        rst_n = 1'b1;
        pop_base = pop_cnt;
        cyc();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check({tag, "_valid"}, valid, 1);
    endtask

    task automatic frame(input string tag, input int eq, input int ep);
        wait_valid(tag);
        check({tag, "_qid"}, qid, eq);
        check({tag, "_pages"}, pages, ep);
        cyc();
        check({tag, "_wait_busy"}, busy, 1);
        check({tag, "_wait_valid"}, valid, 0);
        rd_done = 1'b1;
        cyc();
        rd_done = 1'b0;
        check({tag, "_done_busy"}, busy, 0);
    endtask

    initial begin
        // T1: single descriptor, pop-to-valid latency and pages
        do_reset("t1");
        ready = 1'b1;
        fifo[0].push_back(d(9'h012, 11'd65));
        cyc();
        check("t1_pop", q_pop, 4'b0001);
        check("t1_pre_busy", busy, 0);
        cyc();
        check("t1_pop_once", q_pop, 0);
        check("t1_valid", valid, 1);
        check("t1_ptr", ptr, 9'h012);
        check("t1_len", len, 65);
        check("t1_pages", pages, 2);
        check("t1_qid", qid, 0);
        cyc();
        check("t1_wait_valid", valid, 0);
        check("t1_wait_busy", busy, 1);
        cyc();
        check("t1_wait_busy2", busy, 1);
        rd_done = 1'b1;
        cyc();
        rd_done = 1'b0;
        check("t1_idle", busy, 0);
        check("t1_popcnt", pop_cnt - pop_base, 1);

        // T2: all queues loaded, grant order and page math
        do_reset("t2");
        ready = 1'b1;
        fifo[0].push_back(d(9'h001, 11'd64));
        fifo[0].push_back(d(9'h005, 11'd1518));
        fifo[1].push_back(d(9'h002, 11'd1));
        fifo[2].push_back(d(9'h003, 11'd128));
        fifo[3].push_back(d(9'h004, 11'd129));
`ifdef RD_SCHED_STRICT_PRIO_EN
        e_q = '{0, 0, 1, 2, 3};
        e_p = '{1, 24, 1, 2, 3};
`else
        e_q = '{0, 1, 2, 3, 0};
        e_p = '{1, 1, 2, 3, 24};
`endif
        cyc();
        for (int k = 0; k < 5; k++) begin
            frame($sformatf("t2_f%0d", k), e_q[k], e_p[k]);
        end
        check("t2_popcnt", pop_cnt - pop_base, 5);

        // T3: illegal lengths are dropped and still advance the pointer
        do_reset("t3");
        ready = 1'b1;
        fifo[1].push_back(d(9'h000, 11'd0));
        fifo[1].push_back(d(9'h005, 11'd1519));
        cyc();
        check("t3_pop1", q_pop, 4'b0010);
        check("t3_drop0", drop, 0);
        cyc();
        check("t3_drop1", drop, 1);
        check("t3_valid1", valid, 0);
        check("t3_pop2", q_pop, 4'b0010);
        cyc();
        check("t3_drop2", drop, 2);
        check("t3_valid2", valid, 0);
        check("t3_busy2", busy, 0);
        fifo[0].push_back(d(9'h003, 11'd10));
        fifo[2].push_back(d(9'h004, 11'd20));
        cyc();
`ifdef RD_SCHED_STRICT_PRIO_EN
        check("t3_rr_pop", q_pop, 4'b0001);
        frame("t3_fa", 0, 1);
        frame("t3_fb", 2, 1);
`else
        check("t3_rr_pop", q_pop, 4'b0100);
        frame("t3_fa", 2, 1);
        frame("t3_fb", 0, 1);
`endif
        check("t3_drop_end", drop, 2);

        // T4: back-pressure in ISSUE, early rd_done ignored
        do_reset("t4");
        fifo[3].push_back(d(9'h1AB, 11'd700));
        cyc();
        cyc();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4_valid%0d", k), valid, 1);
            check($sformatf("t4_desc%0d", k), {ptr, len, pages, qid}, {9'h1AB, 11'd700, 6'd11, 2'd3});
            if (k == 1) rd_done = 1'b1;
            if (k == 2) rd_done = 1'b0;
            cyc();
        end
        check("t4_still_valid", valid, 1);
        ready = 1'b1;
        cyc();
        check("t4_wait_valid", valid, 0);
        check("t4_wait_busy", busy, 1);
        cyc();
        check("t4_wait_busy2", busy, 1);
        check("t4_popcnt", pop_cnt - pop_base, 1);
        rd_done = 1'b1;
        cyc();
        rd_done = 1'b0;
        check("t4_idle", busy, 0);

        // T5: flush in ISSUE and WAIT_DONE
        do_reset("t5");
        fifo[0].push_back(d(9'h001, 11'd100));
        fifo[1].push_back(d(9'h002, 11'd200));
        cyc();
        check("t5_pop0", q_pop, 4'b0001);
        cyc();
        check("t5_issue_valid", valid, 1);
        check("t5_issue_qid", qid, 0);
        flush = 1'b1;
        cyc();
        check("t5_fl_valid", valid, 0);
        check("t5_fl_busy", busy, 0);
        check("t5_fl_nopop", q_pop, 0);
        check("t5_fl_drop", drop, 0);
        flush = 1'b0;
        #1;
        check("t5_pop1", q_pop, 4'b0010);
        ready = 1'b1;
        wait_valid("t5_q1");
        check("t5_q1_qid", qid, 1);
        check("t5_q1_len", len, 200);
        cyc();
        check("t5_wait_busy", busy, 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t5_fl2_busy", busy, 0);
        check("t5_fl2_valid", valid, 0);
        check("t5_fl2_drop", drop, 0);
        check("t5_popcnt", pop_cnt - pop_base, 2);

        // T6: drop counter saturation, then async reset mid-WAIT_DONE
        do_reset("t6");
        ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            fifo[2].push_back(d(9'(k), (k % 2 == 0) ? 11'd0 : 11'd2000));
        end
        cyc();
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check($sformatf("t6_drop%0d", k), drop, (k > 15) ? 15 : k);
        end
        check("t6_no_valid", valid, 0);
        fifo[2].push_back(d(9'h0AA, 11'd1600));
        cyc();
        cyc();
        check("t6_sat", drop, 4'hF);
        fifo[0].push_back(d(9'h007, 11'd300));
        cyc();
        cyc();
        check("t6_issue", valid, 1);
        cyc();
        check("t6_wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_arst_busy", busy, 0);
        check("t6_arst_drop", drop, 0);
        check("t6_arst_valid", valid, 0);
        check("t6_arst_desc", {ptr, len, pages, qid}, 0);
        cyc();
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
